// File: rtl/pipe_regs_if.sv
// Pipeline-register chain bus: per-boundary payload/valid plus stall/flush control and retire/perf outputs.
// The master side (core top) drives payloads and control; the slave side (pipe_regs) returns registered state.
interface pipe_regs_if #(
    parameter int unsigned STAGES        = 4,
    parameter int unsigned PAYLOAD_WIDTH = 64,
    parameter int unsigned DATA_WIDTH    = 32
);
    localparam int unsigned BUS_WIDTH = STAGES * PAYLOAD_WIDTH;

    logic                  in_valid;
    logic [BUS_WIDTH-1:0]  stage_d;
    logic [STAGES-1:0]     stall;
    logic [STAGES-1:0]     flush;
    logic [BUS_WIDTH-1:0]  stage_q;
    logic [STAGES-1:0]     valid_q;
    logic                  retire;
    logic [DATA_WIDTH-1:0] retire_count;
    logic [DATA_WIDTH-1:0] stall_count;

    modport master (
        output in_valid, stage_d, stall, flush,
        input  stage_q, valid_q, retire, retire_count, stall_count
    );

    modport slave (
        input  in_valid, stage_d, stall, flush,
        output stage_q, valid_q, retire, retire_count, stall_count
    );
endinterface

// File: rtl/pipe_regs.sv
// Parametrised pipeline-register chain with per-boundary stall/flush, bubble insertion,
// a combinational retire pulse and wrapping retire/stall performance counters.
module pipe_regs #(
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              STAGES        = 4,
    parameter int unsigned              PAYLOAD_WIDTH = 64,
    parameter logic [PAYLOAD_WIDTH-1:0] BUBBLE        = PAYLOAD_WIDTH'(32'h0000_0013)
) (
    input  logic       clk,
    input  logic       rst,
    pipe_regs_if.slave bus
);

    logic [STAGES-1:0]     es_c;
    logic [STAGES-1:0]     up_valid_c;
    logic [STAGES-1:0]     up_stall_c;
    logic [STAGES-1:0]     valid_vec;
    logic                  retire_c;
    logic                  stall_any_c;
    logic [DATA_WIDTH-1:0] retire_cnt_d, retire_cnt_q;
    logic [DATA_WIDTH-1:0] stall_cnt_d, stall_cnt_q;

    // Upstream view for each boundary: boundary 0 is fed by the pipeline input.
    assign up_valid_c = {valid_vec[STAGES-2:0], bus.in_valid};
    assign up_stall_c = {bus.stall[STAGES-2:0], 1'b0};

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic                     v_d, v_q;
        logic [PAYLOAD_WIDTH-1:0] p_d, p_q;

        // A stall anywhere downstream freezes this boundary too.
        assign es_c[g] = |bus.stall[STAGES-1:g];

        always_comb begin
            v_d = v_q;
            p_d = p_q;
            if (bus.flush[g]) begin
                v_d = 1'b0;
                p_d = BUBBLE;
            end else if (!es_c[g]) begin
                if (up_stall_c[g]) begin
                    v_d = 1'b0;
                    p_d = BUBBLE;
                end else begin
                    v_d = up_valid_c[g];
                    p_d = bus.stage_d[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                p_q <= BUBBLE;
            end else begin
                v_q <= v_d;
                p_q <= p_d;
            end
        end

        assign valid_vec[g]                                     = v_q;
        assign bus.stage_q[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]    = p_q;
    end

    assign bus.valid_q = valid_vec;

    // The oldest entry leaves only if it is valid, not held and not squashed.
    assign retire_c    = valid_vec[STAGES-1] & ~es_c[STAGES-1] & ~bus.flush[STAGES-1];
    assign stall_any_c = |bus.stall;

    always_comb begin
        retire_cnt_d = retire_cnt_q + DATA_WIDTH'(retire_c);
        stall_cnt_d  = stall_cnt_q + DATA_WIDTH'(stall_any_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.retire       = retire_c;
    assign bus.retire_count = retire_cnt_q;
    assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_regs.sv
// Directed bench for pipe_regs: reset, flow, stall bubbles, flush priority, branch squash,
// counter wrap (4-bit counters) and mid-stream reset. Top-level wiring feeds slice i from stage_q slice i-1.
module tb_pipe_regs;
    localparam int unsigned DW = 4;
    localparam int unsigned ST = 4;
    localparam int unsigned PW = 64;
    localparam logic [PW-1:0] NOP = 64'h13;

    logic          clk;
    logic          rst;
    logic [PW-1:0] d0;
    int            n_chk;
    int            n_err;
    logic [3:0]    exp_flow [8];

    pipe_regs_if #(.STAGES(ST), .PAYLOAD_WIDTH(PW), .DATA_WIDTH(DW)) pif ();

    pipe_regs #(.DATA_WIDTH(DW), .STAGES(ST), .PAYLOAD_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pif.stage_d = {pif.stage_q[(ST-1)*PW-1:0], d0};

    function automatic logic [PW-1:0] slc(input int i);
        return pif.stage_q[i*PW +: PW];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_flow = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

        // Reset with live-looking inputs
        rst = 1'b1; pif.in_valid = 1'b1; d0 = 64'hDEAD_BEEF_0000_00FF;
        pif.stall = '0; pif.flush = '0;
        tick(); tick();
        chk("rst_valid", 64'(pif.valid_q), 64'h0);
        for (int i = 0; i < int'(ST); i++) chk($sformatf("rst_slice%0d", i), slc(i), NOP);
        chk("rst_rcount", 64'(pif.retire_count), 64'h0);
        chk("rst_scount", 64'(pif.stall_count), 64'h0);
        chk("rst_retire", 64'(pif.retire), 64'h0);
        rst = 1'b0;

        // Flow: four instructions back to back
        for (int k = 0; k < 8; k++) begin
            pif.in_valid = (k < 4);
            d0 = (k < 4) ? 64'hA0 + 64'(k) : 64'h0;
            tick();
            chk("flow_valid", 64'(pif.valid_q), 64'(exp_flow[k]));
            chk("flow_retire", 64'(pif.retire), 64'(exp_flow[k][3]));
            if (k >= 3 && k <= 6) chk("flow_slice3", slc(3), 64'hA0 + 64'(k - 3));
        end
        chk("flow_rcount", 64'(pif.retire_count), 64'd4);

        // Stall at boundary 1 for two cycles
        pif.in_valid = 1'b1; d0 = 64'hB0; tick();
        d0 = 64'hB1; tick();
        chk("stall_pre_valid", 64'(pif.valid_q), 64'h3);
        pif.stall = 4'b0010; d0 = 64'hB2;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_valid", 64'(pif.valid_q), 64'h3);
            chk("stall_slice0", slc(0), 64'hB1);
            chk("stall_slice1", slc(1), 64'hB0);
            chk("stall_bubble2", slc(2), NOP);
        end
        chk("stall_scount", 64'(pif.stall_count), 64'd2);
        pif.stall = '0; pif.in_valid = 1'b0; d0 = 64'h0;
        tick();
        chk("stall_rel_valid", 64'(pif.valid_q), 64'h6);
        chk("stall_rel_slice1", slc(1), 64'hB1);
        chk("stall_rel_slice2", slc(2), 64'hB0);
        tick();
        chk("stall_rel_valid2", 64'(pif.valid_q), 64'hC);
        chk("stall_rel_slice3", slc(3), 64'hB0);
        chk("stall_rel_retire", 64'(pif.retire), 64'h1);
        tick(); tick();
        chk("stall_done_valid", 64'(pif.valid_q), 64'h0);
        chk("stall_done_rcount", 64'(pif.retire_count), 64'd6);

        // Flush beats stall on the same boundary
        pif.in_valid = 1'b1;
        d0 = 64'hC0; tick();
        d0 = 64'hC1; tick();
        d0 = 64'hC2; tick();
        chk("fp_pre_valid", 64'(pif.valid_q), 64'h7);
        pif.stall = 4'b0100; pif.flush = 4'b0100; d0 = 64'hC3;
        tick();
        pif.stall = '0; pif.flush = '0;
        chk("fp_valid", 64'(pif.valid_q), 64'h3);
        chk("fp_slice0", slc(0), 64'hC2);
        chk("fp_slice1", slc(1), 64'hC1);
        chk("fp_slice2", slc(2), NOP);
        chk("fp_scount", 64'(pif.stall_count), 64'd3);

        // Branch squash of the two youngest boundaries
        d0 = 64'hD0; tick();
        d0 = 64'hD1; tick();
        chk("sq_pre_valid", 64'(pif.valid_q), 64'hF);
        chk("sq_pre_slice3", slc(3), 64'hC1);
        pif.flush = 4'b0011; d0 = 64'hD2;
        tick();
        pif.flush = '0; pif.in_valid = 1'b0; d0 = 64'h0;
        chk("sq_valid", 64'(pif.valid_q), 64'hC);
        chk("sq_slice0", slc(0), NOP);
        chk("sq_slice2", slc(2), 64'hD0);
        chk("sq_slice3", slc(3), 64'hC2);
        chk("sq_rcount", 64'(pif.retire_count), 64'd7);
        tick(); tick(); tick();
        chk("sq_done_valid", 64'(pif.valid_q), 64'h0);
        chk("sq_done_rcount", 64'(pif.retire_count), 64'd9);

        // Counter wrap: 17 retirements on a 4-bit counter
        rst = 1'b1; tick(); rst = 1'b0;
        chk("wrap_rst_scount", 64'(pif.stall_count), 64'h0);
        chk("wrap_rst_rcount", 64'(pif.retire_count), 64'h0);
        for (int n = 1; n <= 21; n++) begin
            pif.in_valid = (n <= 17);
            d0 = 64'h100 + 64'(n);
            tick();
            if (n == 19) chk("wrap_rcount15", 64'(pif.retire_count), 64'd15);
            if (n == 20) chk("wrap_rcount0", 64'(pif.retire_count), 64'd0);
            if (n == 21) chk("wrap_rcount1", 64'(pif.retire_count), 64'd1);
        end

        // Reset with a full pipe and a pending stall
        pif.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d0 = 64'hE0 + 64'(k);
            tick();
        end
        chk("mid_full_valid", 64'(pif.valid_q), 64'hF);
        chk("mid_full_rcount", 64'(pif.retire_count), 64'd1);
        pif.stall = 4'b0001; rst = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(pif.valid_q), 64'h0);
        chk("mid_rst_rcount", 64'(pif.retire_count), 64'h0);
        chk("mid_rst_scount", 64'(pif.stall_count), 64'h0);
        chk("mid_rst_slice0", slc(0), NOP);
        chk("mid_rst_slice3", slc(3), NOP);
        rst = 1'b0; pif.stall = '0; pif.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_regs.md
Name: pipe_regs

Overview:
Parametrised pipeline-register chain for the next-generation pipelined core. It replaces direct fetch→decode→execute wiring with STAGES clocked boundaries (default IF/ID, ID/EX, EX/MEM, MEM/WB). Each boundary has a valid bit, per-stage stall and flush with bubble insertion, and a retire pulse. It also keeps retire and stall performance counters for the top level.

Parameters:
DATA_WIDTH, 32, width of the two counters
STAGES, 4, number of pipeline boundaries (≥2)
PAYLOAD_WIDTH, 64, bits latched per boundary (packed control + data fields chosen by top)
BUBBLE, {PAYLOAD_WIDTH{1'b0}} with low 32 bits = 32'h00000013, payload loaded on reset/flush/bubble (NOP)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  stage-0 input carries a real instruction
stage_d  input  STAGES*PAYLOAD_WIDTH  next payload per boundary, slice i = [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
stall  input  STAGES  stall request per boundary
flush  input  STAGES  flush request per boundary
stage_q  output  STAGES*PAYLOAD_WIDTH  registered payload per boundary
valid_q  output  STAGES  registered valid per boundary
retire  output  1  combinational: last boundary holds a valid instr leaving this cycle
retire_count  output  DATA_WIDTH  instructions retired since reset
stall_count  output  DATA_WIDTH  cycles with any stall bit set since reset

Behaviour:
- Reset (rst=1 at edge): all valid_q=0; all stage_q slices=BUBBLE; both counters=0. Reset overrides every other input. It takes effect mid-stream, discarding in-flight entries.
- Effective stall: es[i] = OR of stall[j] for j≥i, so a stall freezes its own boundary and every earlier one.
- Per boundary i, each edge, in priority order:
  1. flush[i]: valid_q[i]←0, slice←BUBBLE. Flush beats stall.
  2. es[i]: hold valid_q[i] and the slice.
  3. i>0 and stall[i-1] (downstream free, upstream frozen): insert bubble; valid_q[i]←0, slice←BUBBLE.
  4. else: slice←stage_d slice i; valid_q[i]←(i==0 ? in_valid : valid_q[i-1]).
- Latency: an unstalled instruction entering at boundary 0 on edge N reaches boundary STAGES-1 on edge N+STAGES-1.
- retire = valid_q[STAGES-1] & ~es[STAGES-1] & ~flush[STAGES-1].
- retire_count increments by 1 on each edge where retire=1.
- stall_count increments by 1 on each edge where |stall=1.
- Both counters wrap modulo 2^DATA_WIDTH. No saturation.
- Simultaneous stall[i] and flush[i]: boundary i flushes. Earlier boundaries still hold via es.
- Flush of boundary i does not affect other boundaries. The top asserts a multi-bit flush for branch squash, e.g. flush=4'b0011.
- Invalid entries move through the chain like valid ones but never retire.
- No combinational path from stage_d to stage_q.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 and stage_d non-zero → valid_q=0, every slice low 32 bits = 0x00000013, both counters 0.
- Flow: STAGES=4, no stall or flush; on 4 consecutive cycles drive in_valid=1, stage_d slice0=0xA0..0xA3 → valid_q[3]=1 exactly 3 edges after each entry; retire high 4 cycles; retire_count=4.
- Stall: while an instr is at boundary 1, hold stall[1]=1 for 2 cycles → boundaries 0 and 1 hold payloads; boundary 2 gets a bubble (valid_q[2]=0, low bits 0x13) each cycle; stall_count=2; no payload lost after release.
- Flush priority: stall[2]=1 and flush[2]=1 on the same edge → valid_q[2]=0, slice=BUBBLE, boundaries 0-1 held.
- Branch squash: flush=4'b0011 with all boundaries valid → valid_q=4'b1100 next cycle; only the 2 older instrs retire.
- Wrap and reset mid-operation: DATA_WIDTH=4, retire 17 instrs → retire_count=1. Then assert rst with a full pipe → all valid_q=0 and counters=0 next edge.
